// File: rtl/dlyd_chain_tdc_pkg.sv
// ---------------------------------------------------------------------------
// dlyd_chain_tdc_pkg
//   Shared definitions for the dlyd chain time-to-digital converter:
//   measurement FSM state encoding, the chain settle time, and width helpers
//   for the tap-count and accumulator vectors.
// ---------------------------------------------------------------------------
package dlyd_chain_tdc_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETTLE = 3'd1,
        ST_FIRE   = 3'd2,
        ST_SYNC   = 3'd3,
        ST_ACCUM  = 3'd4,
        ST_DONE   = 3'd5
    } state_e;

    // Cycles LAUNCH is held low before each firing so the chain discharges.
    localparam int SETTLE_CYCLES = 2;

    // Width able to hold any tap count 0..taps inclusive.
    function automatic int cnt_width(input int taps);
        return $clog2(taps + 1);
    endfunction

    // Accumulator width: large enough for 2^avg_log2 full-scale samples.
    function automatic int acc_width(input int cnt_w, input int avg_log2);
        return cnt_w + avg_log2;
    endfunction

endpackage

// File: rtl/dlyd_chain_tdc_therm_decode.sv
// ---------------------------------------------------------------------------
// dlyd_therm_decode
//   Combinational thermometer decoder for the sampled chain taps.
//   Ports:
//     therm    in  [TAPS]   sampled tap vector, tap 0 nearest the launch point
//     count    out [CNT_W]  run length of 1s starting at tap 0
//     bubble   out          a 1 exists above the first 0
//     all_ones out          every tap is 1 (edge outran the chain)
// ---------------------------------------------------------------------------
module dlyd_therm_decode
    import dlyd_chain_tdc_pkg::*;
#(
    parameter int TAPS  = 16,
    parameter int CNT_W = cnt_width(TAPS)
) (
    input  logic [TAPS-1:0]  therm,
    output logic [CNT_W-1:0] count,
    output logic             bubble,
    output logic             all_ones
);

    logic run;

    // Walk up from tap 0: count while the run of 1s is unbroken; any 1 seen
    // after the run has ended is a bubble and does not add to the count.
    always_comb begin
        run    = 1'b1;
        count  = '0;
        bubble = 1'b0;
        for (int i = 0; i < TAPS; i++) begin
            if (run && therm[i]) begin
                count = count + CNT_W'(1);
            end else if (!therm[i]) begin
                run = 1'b0;
            end else begin
                bubble = 1'b1;
            end
        end
    end

    assign all_ones = &therm;

endmodule

// File: rtl/dlyd_chain_tdc.sv
// ---------------------------------------------------------------------------
// dlyd_chain_tdc
//   Launches an edge into an external dlyd delay chain, captures the chain's
//   thermometer taps through a two-stage synchroniser, decodes each sample to
//   a tap count and averages 2^AVG_LOG2 samples per measurement.
//
//   Valid/ready note: START is a request sampled only in IDLE (ignored while
//   BUSY, never queued); DONE is a one-cycle pulse from which CODE, AVG,
//   BUBBLE_ERR and OVR are valid and held until the next DONE.
//
//   Ports:
//     CLK        in        clock, rising edge
//     RST        in        synchronous active-high reset (aborts a measurement)
//     START      in        measurement request
//     LAUNCH     out       registered drive into the chain input
//     TAPS_IN    in [TAPS] chain taps, asynchronous to CLK
//     BUSY       out       measurement in progress
//     DONE       out       one-cycle completion pulse
//     CODE       out       tap count of the most recent sample
//     AVG        out       accumulated sum >> AVG_LOG2
//     BUBBLE_ERR out       some sample in this measurement had a bubble
//     OVR        out       some sample in this measurement was all ones
//     STATE_DBG  out [3]   current FSM state (debug observation)
// ---------------------------------------------------------------------------
module dlyd_chain_tdc
    import dlyd_chain_tdc_pkg::*;
#(
    parameter int TAPS     = 16,
    parameter int AVG_LOG2 = 3,
    parameter int CNT_W    = cnt_width(TAPS)
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    output logic             LAUNCH,
    input  logic [TAPS-1:0]  TAPS_IN,
    output logic             BUSY,
    output logic             DONE,
    output logic [CNT_W-1:0] CODE,
    output logic [CNT_W-1:0] AVG,
    output logic             BUBBLE_ERR,
    output logic             OVR,
    output logic [2:0]       STATE_DBG
);

    localparam int ACC_W = acc_width(CNT_W, AVG_LOG2);
    localparam int SMP_W = AVG_LOG2 + 1;
    localparam int SET_W = $clog2(SETTLE_CYCLES + 1);
    localparam logic [SMP_W-1:0] SMP_LAST = SMP_W'((1 << AVG_LOG2) - 1);
    localparam logic [SET_W-1:0] SET_LAST = SET_W'(SETTLE_CYCLES - 1);

    state_e            state_q,  state_d;
    logic [SET_W-1:0]  settle_q, settle_d;
    logic [SMP_W-1:0]  smp_q,    smp_d;
    logic [ACC_W-1:0]  acc_q,    acc_d;
    logic [TAPS-1:0]   tap_s1_q, tap_s1_d;
    logic [TAPS-1:0]   tap_s2_q, tap_s2_d;
    logic              launch_q, launch_d;
    logic              busy_q,   busy_d;
    logic              done_q,   done_d;
    logic [CNT_W-1:0]  code_q,   code_d;
    logic [CNT_W-1:0]  avg_q,    avg_d;
    logic              bubble_q, bubble_d;
    logic              ovr_q,    ovr_d;

    logic [CNT_W-1:0]  dec_count;
    logic              dec_bubble;
    logic              dec_all_ones;

    // Decoder only ever sees the second synchroniser stage.
    dlyd_therm_decode #(
        .TAPS  (TAPS),
        .CNT_W (CNT_W)
    ) u_decode (
        .therm    (tap_s2_q),
        .count    (dec_count),
        .bubble   (dec_bubble),
        .all_ones (dec_all_ones)
    );

    always_comb begin
        state_d  = state_q;
        settle_d = settle_q;
        smp_d    = smp_q;
        acc_d    = acc_q;
        tap_s1_d = tap_s1_q;
        tap_s2_d = tap_s2_q;
        launch_d = 1'b0;
        busy_d   = busy_q;
        done_d   = 1'b0;
        code_d   = code_q;
        avg_d    = avg_q;
        bubble_d = bubble_q;
        ovr_d    = ovr_q;

        case (state_q)
            ST_IDLE: begin
                if (START) begin
                    state_d  = ST_SETTLE;
                    settle_d = '0;
                    smp_d    = '0;
                    acc_d    = '0;
                    bubble_d = 1'b0;
                    ovr_d    = 1'b0;
                    busy_d   = 1'b1;
                end
            end
            ST_SETTLE: begin
                // LAUNCH is registered, so it is raised on the edge that
                // enters FIRE and is high for the whole FIRE cycle.
                if (settle_q == SET_LAST) begin
                    state_d  = ST_FIRE;
                    launch_d = 1'b1;
                end else begin
                    settle_d = settle_q + SET_W'(1);
                end
            end
            ST_FIRE: begin
                tap_s1_d = TAPS_IN;
                state_d  = ST_SYNC;
            end
            ST_SYNC: begin
                tap_s2_d = tap_s1_q;
                state_d  = ST_ACCUM;
            end
            ST_ACCUM: begin
                code_d   = dec_count;
                acc_d    = acc_q + ACC_W'(dec_count);
                bubble_d = bubble_q | dec_bubble;
                ovr_d    = ovr_q | dec_all_ones;
                smp_d    = smp_q + SMP_W'(1);
                settle_d = '0;
                if (smp_q == SMP_LAST) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_SETTLE;
                end
            end
            ST_DONE: begin
                avg_d   = acc_q[ACC_W-1:AVG_LOG2];
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= ST_IDLE;
            settle_q <= '0;
            smp_q    <= '0;
            acc_q    <= '0;
            tap_s1_q <= '0;
            tap_s2_q <= '0;
            launch_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            code_q   <= '0;
            avg_q    <= '0;
            bubble_q <= 1'b0;
            ovr_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            settle_q <= settle_d;
            smp_q    <= smp_d;
            acc_q    <= acc_d;
            tap_s1_q <= tap_s1_d;
            tap_s2_q <= tap_s2_d;
            launch_q <= launch_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            code_q   <= code_d;
            avg_q    <= avg_d;
            bubble_q <= bubble_d;
            ovr_q    <= ovr_d;
        end
    end

    assign LAUNCH     = launch_q;
    assign BUSY       = busy_q;
    assign DONE       = done_q;
    assign CODE       = code_q;
    assign AVG        = avg_q;
    assign BUBBLE_ERR = bubble_q;
    assign OVR        = ovr_q;
    assign STATE_DBG  = state_q;

endmodule

// File: doc/dlyd_chain_tdc.md
Name: dlyd_chain_tdc

Overview:
- Receive-side companion to the dlyd delay buffer: launches an edge into an external chain of dlyd cells and captures the chain's thermometer-coded tap outputs one clock later.
- Decodes the taps to a tap count and averages 2^AVG_LOG2 samples, giving a delay-per-clock measurement.
- Used for on-chip characterisation and calibration of dlyd delay chains; sits between the chain and a digital control or readout block.

Parameters:
- TAPS, 16, number of chain taps sampled (tap 0 is nearest the launch point).
- AVG_LOG2, 3, log2 of the number of samples averaged per measurement (8 samples).
- CNT_W, $clog2(TAPS+1), derived; width of the tap-count result.

Ports:
- CLK  input  1  single clock; all state updates on the rising edge.
- RST  input  1  synchronous, active-high reset.
- START  input  1  request a measurement; sampled only in IDLE.
- LAUNCH  output  1  registered drive into the delay chain input.
- TAPS_IN  input  TAPS  chain tap outputs; asynchronous to CLK.
- BUSY  output  1  high from the cycle after START is accepted until DONE.
- DONE  output  1  one-cycle pulse; results valid from this cycle on.
- CODE  output  CNT_W  decoded count of the most recent sample.
- AVG  output  CNT_W  accumulated sum >> AVG_LOG2, truncated.
- BUBBLE_ERR  output  1  sticky per measurement: some sample had a 1 above a 0.
- OVR  output  1  sticky per measurement: some sample had all taps = 1 (edge outran the chain).

Behaviour:
- Reset (synchronous, active-high RST):
  - State goes to IDLE.
  - LAUNCH=0, BUSY=0, DONE=0, CODE=0, AVG=0, BUBBLE_ERR=0, OVR=0.
  - Accumulator and sample counter are cleared.
- RST asserted mid-measurement aborts it: the outputs above go to their reset values on that edge, no DONE is issued, and partial results are discarded.
- IDLE:
  - LAUNCH=0.
  - START=1 moves to SETTLE, clears the accumulator, sample counter, BUBBLE_ERR and OVR, and sets BUSY=1.
  - AVG and CODE keep their previous values until the next DONE.
- SETTLE: 2 cycles with LAUNCH=0 so the chain discharges; then go to FIRE.
- FIRE: 1 cycle with LAUNCH=1. On the closing edge the capture register samples TAPS_IN (stage 1 of the synchroniser); then go to SYNC.
- SYNC: 1 cycle; the stage-2 register takes the stage-1 value; then go to ACCUM.
- ACCUM (1 cycle), acting on the stage-2 value:
  - Decode: count = number of consecutive 1s starting at tap 0, stopping at the first 0.
  - Any 1 above the first 0 sets BUBBLE_ERR; bubbles do not change the count.
  - All ones gives count = TAPS and sets OVR.
  - CODE <= count; acc <= acc + count, with acc CNT_W+AVG_LOG2 bits wide so it cannot overflow; sample counter increments.
  - If the counter reaches 2^AVG_LOG2, go to DONE; otherwise go back to SETTLE.
- DONE:
  - AVG <= acc[CNT_W+AVG_LOG2-1:AVG_LOG2].
  - DONE=1 for exactly this cycle; BUSY drops in the same cycle.
  - Next state is IDLE.
- Timing:
  - Each sample takes 5 cycles.
  - From the START-accepted edge to DONE high: 5*2^AVG_LOG2 + 1 cycles (41 at defaults).
- START while BUSY is ignored, not queued. START held high re-arms in the first IDLE cycle after DONE.
- LAUNCH comes straight from a flop, never from combinational logic.
- TAPS_IN reaches the logic only through the two-stage capture/sync path.

Decomposition:
- Shared package:
  - state enum {IDLE, SETTLE, FIRE, SYNC, ACCUM, DONE};
  - SETTLE_CYCLES = 2 constant;
  - a function for the width of the CNT_W and accumulator vectors.
- One natural sub-module: dlyd_therm_decode, combinational, parameterised by TAPS. It takes a TAPS-bit thermometer vector and outputs count [CNT_W], bubble and all_ones.
- The FSM, synchroniser and accumulator stay in the top module.

Test Plan:
- TAPS_IN fixed to 16'h003F (6 ones), START pulsed -> LAUNCH shows 8 pulses, each 1 cycle high and 4 low; DONE at cycle 41; CODE=6, AVG=6, BUBBLE_ERR=0, OVR=0.
- TAPS_IN alternating per sample between 16'h000F and 16'h001F (4,5,4,5,...) -> sum 36; AVG=4 (truncated), CODE=5.
- One sample with TAPS_IN = 16'h00F7 (bubble at tap 3) -> that sample decodes to 3 and BUBBLE_ERR=1 at DONE; the next measurement with clean taps reports BUBBLE_ERR=0.
- TAPS_IN = 16'hFFFF on all samples -> CODE=16, AVG=16, OVR=1; the accumulator value is exactly 128 with no wrap.
- RST=1 during the 3rd ACCUM cycle -> on that edge LAUNCH=0, BUSY=0, AVG=0, CODE=0, and no DONE follows. A fresh START then completes normally in 41 cycles.
- START pulsed again while BUSY=1 at cycle 10 -> ignored: exactly one DONE at cycle 41, and BUSY low afterwards.
